mat_skew_feeder: RTL and testbench
==================================

Name: mat_skew_feeder

Overview:
- Transmit-side companion to the systolic matrix-multiply array.
- Accepts an MxM A matrix (row per beat) and an MxM B matrix (column per beat) into local storage.
- Streams the diagonally skewed, zero-padded operand wavefront into the array's a/b ports under a valid/ready handshake, then appends flush beats.
- Sits between the operand source (DMA/testbench) and the array.

Parameters:
- M, 3, square matrix width; M >= 2.
- FLUSH, 2, zero beats appended after the 3M-2 skewed beats.

Ports:
- CLK  input  1  clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- ld_vld  input  1  load beat valid.
- ld_rdy  output  1  feeder can accept a load beat.
- ld_a  input  8*M  one row of A; byte c at bits [8*(M-c)-1 -: 8] (column 0 in the MSB byte).
- ld_b  input  8*M  one column of B; byte r at bits [8*(M-r)-1 -: 8] (row 0 in the MSB byte).
- a  output  8*M  skewed A lanes to the array; lane i at [8*(M-i)-1 -: 8].
- b  output  8*M  skewed B lanes to the array; lane j at [8*(M-j)-1 -: 8].
- arr_vld  output  1  a/b valid.
- arr_rdy  input  1  array ready.
- done  output  1  one-cycle pulse after the last stream beat is accepted.
- stall_cnt  output  16  stall counter (see Optional Feature).

Behaviour:
- Clock and reset: single clock CLK. Reset rst is synchronous and active-high.
- Reset values: state=LOAD, load count=0, step=0, a=0, b=0, arr_vld=0, done=0, stall_cnt=0, storage contents don't-care.
- Reset asserted mid-load or mid-stream aborts immediately: all of the above return to their reset values, and the partial matrix is discarded.
- State LOAD:
  - ld_rdy=1, arr_vld=0.
  - Each ld_vld&&ld_rdy beat k (0..M-1) writes A[k][*] from ld_a and B[*][k] from ld_b; load count increments.
  - On the edge accepting beat M-1: state goes to STREAM, a/b registers load the step-0 values, and arr_vld=1 from the next cycle. Load-to-first-valid latency is 1 cycle.
- State STREAM:
  - ld_rdy=0; ld_vld is ignored.
  - Step t in 0..3M-3+FLUSH.
  - Lane i of a = A[i][t-i] if 0 <= t-i < M, else 0.
  - Lane j of b = B[t-j][j] if 0 <= t-j < M, else 0.
  - Steps t >= 3M-2 are all-zero flush beats.
- Stream handshake rules:
  - A beat transfers on arr_vld&&arr_rdy. On transfer, step increments and the a/b registers load the next step's values in the same edge.
  - While arr_rdy=0, a, b and arr_vld hold stable; there is no combinational path from arr_rdy to a/b/arr_vld.
  - On transfer of the final step (3M-3+FLUSH): arr_vld=0, a=b=0, done=1 for exactly one cycle, state goes to LOAD, and load count=0.
- Back-to-back operation: ld_rdy rises the same cycle done pulses, so a new matrix load may begin immediately. There is no overlap of load and stream.
- Operand arithmetic: none; the block is a pure byte mover. Step and load counters are $clog2(3M+FLUSH) and $clog2(M+1) bits wide respectively, with no wrap inside an operation.
- Beats per operation: exactly 3M-2+FLUSH accepted beats, i.e. 9 for M=3, FLUSH=2.

Optional Feature:
- Macro: SKEW_FEEDER_STALL_CNT_EN.
- Defined:
  - stall_cnt increments each cycle with arr_vld=1 and arr_rdy=0, saturating at 16'hFFFF.
  - It clears to 0 on the LOAD-to-STREAM transition.
  - It holds its value in LOAD, so it is readable after done.
- Undefined: stall_cnt is tied to 0 and no counter logic is synthesized.

Test Plan:
- Reset then load, with M=3, A=[[1,2,3],[4,5,6],[7,8,9]], B=identity, arr_rdy=1:
  - Beats in order: a=0x010000, 0x020400, 0x030507, 0x000608, 0x000009, then 0 for the remaining 4 beats.
  - b=0x010000, 0x000000, 0x000100, 0x000000, 0x000001, then 0.
  - done pulses one cycle after the 9th beat.
- Same load with arr_rdy toggling 1,0,0,1,...:
  - a/b hold stable during the low cycles.
  - Beat sequence is identical to the first scenario; exactly 9 transfers occur.
  - With the macro defined, stall_cnt equals the number of low-ready cycles seen while arr_vld=1.
- ld_vld asserted during STREAM: ld_rdy=0 and stored A/B are unchanged, verified by a second stream producing identical beats.
- rst pulsed after load beat 1, then after stream beat 4:
  - All outputs are 0 and the state is LOAD the next cycle.
  - A subsequent full load of 3 beats streams correctly from step 0.
- Two matrices loaded back-to-back: the second load's first beat is accepted in the done cycle, and the second stream starts 3 cycles later with correct step-0 data.

Source files
------------

// File: rtl/mat_skew_feeder.sv
// Operand feeder for the systolic matrix-multiply array: loads an MxM A/B pair, then streams the
// diagonally skewed, zero-padded wavefront plus FLUSH zero beats. Define SKEW_FEEDER_STALL_CNT_EN for the stall counter.
module mat_skew_feeder #(
  parameter int M     = 3,
  parameter int FLUSH = 2
) (
  input  logic           CLK,
  input  logic           rst,
  input  logic           ld_vld,
  output logic           ld_rdy,
  input  logic [8*M-1:0] ld_a,
  input  logic [8*M-1:0] ld_b,
  output logic [8*M-1:0] a,
  output logic [8*M-1:0] b,
  output logic           arr_vld,
  input  logic           arr_rdy,
  output logic           done,
  output logic [15:0]    stall_cnt
);
  localparam int SW = $clog2(3*M+FLUSH);
  localparam int CW = $clog2(M+1);
  localparam logic [SW-1:0] LAST_STEP = SW'(3*M-3+FLUSH);
  localparam logic [CW-1:0] LAST_BEAT = CW'(M-1);

  localparam logic [0:0] LOAD   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [0:0]     state;
  logic [CW-1:0]  ld_cnt;
  logic [SW-1:0]  step;
  logic [SW-1:0]  sel_step;
  logic [7:0]     mem_a [M][M];
  logic [7:0]     mem_b [M][M];
  logic [8*M-1:0] nxt_a;
  logic [8*M-1:0] nxt_b;
  logic           ld_fire;
  logic           ld_last;
  logic           xfer;

  assign ld_rdy   = (state == LOAD);
  assign ld_fire  = ld_vld && ld_rdy;
  assign ld_last  = ld_fire && (ld_cnt == LAST_BEAT);
  assign xfer     = arr_vld && arr_rdy;
  // Step 0 only needs A[0][0] and B[0][0], both written on beat 0, so it is safe to read
  // storage on the edge that accepts the final load beat (M >= 2).
  assign sel_step = (state == LOAD) ? '0 : step + SW'(1);

  always_comb begin
    nxt_a = '0;
    nxt_b = '0;
    for (int i = 0; i < M; i++) begin
      for (int k = 0; k < M; k++) begin
        if (sel_step == SW'(i + k)) begin
          nxt_a[8*(M-i)-1 -: 8] = mem_a[i][k];
          nxt_b[8*(M-i)-1 -: 8] = mem_b[k][i];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst && ld_fire) begin
      for (int k = 0; k < M; k++) begin
        if (ld_cnt == CW'(k)) begin
          for (int c = 0; c < M; c++) begin
            mem_a[k][c] <= ld_a[8*(M-c)-1 -: 8];
            mem_b[c][k] <= ld_b[8*(M-c)-1 -: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state   <= LOAD;
      ld_cnt  <= '0;
      step    <= '0;
      a       <= '0;
      b       <= '0;
      arr_vld <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == LOAD) begin
        if (ld_last) begin
          state   <= STREAM;
          ld_cnt  <= '0;
          step    <= '0;
          a       <= nxt_a;
          b       <= nxt_b;
          arr_vld <= 1'b1;
        end else if (ld_fire) begin
          ld_cnt <= ld_cnt + CW'(1);
        end
      end else if (xfer) begin
        if (step == LAST_STEP) begin
          state   <= LOAD;
          ld_cnt  <= '0;
          step    <= '0;
          a       <= '0;
          b       <= '0;
          arr_vld <= 1'b0;
          done    <= 1'b1;
        end else begin
          step <= step + SW'(1);
          a    <= nxt_a;
          b    <= nxt_b;
        end
      end
    end
  end

`ifdef SKEW_FEEDER_STALL_CNT_EN
  // Counts back-pressured cycles of the current stream; left untouched in LOAD so it can be read after done.
  always_ff @(posedge CLK) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (ld_last) begin
      stall_cnt <= '0;
    end else if (arr_vld && !arr_rdy && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mat_skew_feeder.sv
// Self-checking bench for mat_skew_feeder: a matrix-level model of the skewed wavefront checked every cycle,
// plus directed scenarios with hand-computed beat sequences.
module tb_mat_skew_feeder;
  localparam int M      = 3;
  localparam int FLUSH  = 2;
  localparam int W      = 8*M;
  localparam int NBEATS = 3*M-2+FLUSH;
`ifdef SKEW_FEEDER_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  typedef logic [7:0] mat_t [M][M];

  logic          CLK = 1'b0;
  logic          rst;
  logic          ld_vld;
  logic          ld_rdy;
  logic [W-1:0]  ld_a;
  logic [W-1:0]  ld_b;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          arr_vld;
  logic          arr_rdy;
  logic          done;
  logic [15:0]   stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  mat_skew_feeder #(.M(M), .FLUSH(FLUSH)) dut (
    .CLK(CLK), .rst(rst), .ld_vld(ld_vld), .ld_rdy(ld_rdy), .ld_a(ld_a), .ld_b(ld_b),
    .a(a), .b(b), .arr_vld(arr_vld), .arr_rdy(arr_rdy), .done(done), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  mat_t A1 = '{'{8'd1, 8'd2, 8'd3}, '{8'd4, 8'd5, 8'd6}, '{8'd7, 8'd8, 8'd9}};
  mat_t ID = '{'{8'd1, 8'd0, 8'd0}, '{8'd0, 8'd1, 8'd0}, '{8'd0, 8'd0, 8'd1}};
  mat_t A2 = '{'{8'h11, 8'h12, 8'h13}, '{8'h21, 8'h22, 8'h23}, '{8'h31, 8'h32, 8'h33}};
  mat_t B2 = '{'{8'ha1, 8'ha2, 8'ha3}, '{8'hb1, 8'hb2, 8'hb3}, '{8'hc1, 8'hc2, 8'hc3}};
  logic [W-1:0] lit_a1 [NBEATS] = '{24'h010000, 24'h020400, 24'h030507, 24'h000608, 24'h000009, 0, 0, 0, 0};
  logic [W-1:0] lit_b1 [NBEATS] = '{24'h010000, 24'h000000, 24'h000100, 24'h000000, 24'h000001, 0, 0, 0, 0};

  task automatic checkOutput(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // Lane i of a carries A[i][t-i]; lane j of b carries B[t-j][j]; anything out of range is zero.
  function automatic logic [W-1:0] model_a(input int t, input mat_t mat);
    logic [W-1:0] r = '0;
    for (int i = 0; i < M; i++)
      if (t - i >= 0 && t - i < M) r[8*(M-i)-1 -: 8] = mat[i][t-i];
    return r;
  endfunction

  function automatic logic [W-1:0] model_b(input int t, input mat_t mat);
    logic [W-1:0] r = '0;
    for (int j = 0; j < M; j++)
      if (t - j >= 0 && t - j < M) r[8*(M-j)-1 -: 8] = mat[t-j][j];
    return r;
  endfunction

  mat_t          m_a;
  mat_t          m_b;
  bit            chk_en   = 1'b0;
  bit            exp_vld  = 1'b0;
  bit            exp_done = 1'b0;
  int            exp_step = 0;
  int            exp_lcnt = 0;
  int            n_xfer   = 0;
  int            n_low    = 0;
  logic [15:0]   exp_stall = '0;
  logic [W-1:0]  got_a [$];
  logic [W-1:0]  got_b [$];
  int            rdy_mode = 0;

  // Per-cycle compare against the matrix model, sampled mid-cycle.
  always @(negedge CLK) begin
    if (chk_en) begin
      checkOutput("arr_vld", W'(arr_vld), W'(exp_vld));
      checkOutput("ld_rdy", W'(ld_rdy), W'(!exp_vld));
      checkOutput("done", W'(done), W'(exp_done));
      checkOutput("stall_cnt", W'(stall_cnt), STALL_EN ? W'(exp_stall) : '0);
      exp_done = 1'b0;
      if (exp_vld) begin
        checkOutput("a beat", a, model_a(exp_step, m_a));
        checkOutput("b beat", b, model_b(exp_step, m_b));
        if (!arr_rdy) begin
          n_low++;
          if (exp_stall != 16'hFFFF) exp_stall++;
        end else begin
          got_a.push_back(a);
          got_b.push_back(b);
          n_xfer++;
          if (exp_step == NBEATS-1) begin
            exp_vld  = 1'b0;
            exp_done = 1'b1;
            exp_step = 0;
          end else begin
            exp_step++;
          end
        end
      end else begin
        checkOutput("a idle", a, '0);
        checkOutput("b idle", b, '0);
        if (ld_vld) begin
          for (int c = 0; c < M; c++) begin
            m_a[exp_lcnt][c] = ld_a[8*(M-c)-1 -: 8];
            m_b[c][exp_lcnt] = ld_b[8*(M-c)-1 -: 8];
          end
          if (exp_lcnt == M-1) begin
            exp_lcnt  = 0;
            exp_vld   = 1'b1;
            exp_step  = 0;
            exp_stall = '0;
          end else begin
            exp_lcnt++;
          end
        end
      end
      if (rst) begin
        exp_vld   = 1'b0;
        exp_done  = 1'b0;
        exp_step  = 0;
        exp_lcnt  = 0;
        exp_stall = '0;
      end
    end
  end

  initial begin
    int ph = 0;
    arr_rdy = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      if (rdy_mode == 0) begin
        arr_rdy = 1'b1;
      end else begin
        arr_rdy = (ph == 0);
        ph = (ph + 1) % 3;
      end
    end
  end

  task automatic applyStimulus(input mat_t ma, input mat_t mb, input int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      for (int c = 0; c < M; c++) begin
        ld_a[8*(M-c)-1 -: 8] = ma[k][c];
        ld_b[8*(M-c)-1 -: 8] = mb[c][k];
      end
      ld_vld = 1'b1;
      @(posedge CLK);
      #1;
    end
    ld_vld = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!done && k < 200) begin
      @(posedge CLK);
      #1;
      k++;
    end
    checkOutput(name, W'(done), W'(1));
  endtask

  task automatic pulse_reset(input string name);
    rst = 1'b1;
    @(posedge CLK);
    #1;
    rst = 1'b0;
    checkOutput({name, " a"}, a, '0);
    checkOutput({name, " b"}, b, '0);
    checkOutput({name, " arr_vld"}, W'(arr_vld), '0);
    checkOutput({name, " done"}, W'(done), '0);
    checkOutput({name, " ld_rdy"}, W'(ld_rdy), W'(1));
  endtask

  task automatic check_literal_stream(input string name);
    checkOutput({name, " beat count"}, W'(got_a.size()), W'(NBEATS));
    for (int i = 0; i < NBEATS; i++) begin
      checkOutput({name, " a lit"}, (i < got_a.size()) ? got_a[i] : 'x, lit_a1[i]);
      checkOutput({name, " b lit"}, (i < got_b.size()) ? got_b[i] : 'x, lit_b1[i]);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [W-1:0] sv_a [$];
    logic [W-1:0] sv_b [$];
    int k;
    rst = 1'b1;
    ld_vld = 1'b0;
    ld_a = '0;
    ld_b = '0;
    repeat (2) @(posedge CLK);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    checkOutput("reset a", a, '0);
    checkOutput("reset b", b, '0);
    checkOutput("reset arr_vld", W'(arr_vld), '0);
    checkOutput("reset done", W'(done), '0);
    checkOutput("reset ld_rdy", W'(ld_rdy), W'(1));
    checkOutput("reset stall_cnt", W'(stall_cnt), '0);

    checkOutput("model pin a t1", model_a(1, A1), 24'h020400);
    checkOutput("model pin b t2", model_b(2, ID), 24'h000100);
    checkOutput("model pin a2 t2", model_a(2, A2), 24'h132231);
    checkOutput("model pin b2 t2", model_b(2, B2), 24'hc1b2a3);
    checkOutput("model pin flush", model_a(5, A1), '0);

    $display("[TB] scenario: basic stream, ready high");
    got_a.delete(); got_b.delete();
    applyStimulus(A1, ID, M);
    wait_done("basic done");
    check_literal_stream("basic");

    $display("[TB] scenario: ready toggling");
    got_a.delete(); got_b.delete();
    n_low = 0;
    rdy_mode = 1;
    applyStimulus(A1, ID, M);
    wait_done("toggle done");
    rdy_mode = 0;
    check_literal_stream("toggle");
    checkOutput("toggle stall_cnt", W'(stall_cnt), STALL_EN ? W'(n_low) : '0);

    $display("[TB] scenario: ld_vld during stream");
    got_a.delete(); got_b.delete();
    applyStimulus(A2, B2, M);
    ld_a = 24'hdeadbe;
    ld_b = 24'hfeed55;
    ld_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("stream ld_rdy", W'(ld_rdy), '0);
      @(posedge CLK);
      #1;
    end
    ld_vld = 1'b0;
    wait_done("ignore done");
    sv_a = got_a;
    sv_b = got_b;
    got_a.delete(); got_b.delete();
    applyStimulus(A2, B2, M);
    wait_done("restream done");
    checkOutput("restream count", W'(got_a.size()), W'(sv_a.size()));
    for (int i = 0; i < NBEATS; i++) begin
      checkOutput("restream a", (i < got_a.size()) ? got_a[i] : 'x, (i < sv_a.size()) ? sv_a[i] : 'x);
      checkOutput("restream b", (i < got_b.size()) ? got_b[i] : 'x, (i < sv_b.size()) ? sv_b[i] : 'x);
    end
    checkOutput("restream a t2", (got_a.size() > 2) ? got_a[2] : 'x, 24'h132231);

    $display("[TB] scenario: reset mid-load");
    applyStimulus(A2, B2, 2);
    pulse_reset("midload rst");
    got_a.delete(); got_b.delete();
    applyStimulus(A1, ID, M);
    wait_done("after midload done");
    check_literal_stream("after midload");

    $display("[TB] scenario: reset mid-stream");
    n_xfer = 0;
    applyStimulus(A2, B2, M);
    k = 0;
    while (n_xfer < 4 && k < 100) begin
      @(posedge CLK);
      #1;
      k++;
    end
    checkOutput("midstream reached beat 4", W'(n_xfer), W'(4));
    pulse_reset("midstream rst");
    got_a.delete(); got_b.delete();
    applyStimulus(A1, ID, M);
    wait_done("after midstream done");
    check_literal_stream("after midstream");

    $display("[TB] scenario: back-to-back");
    got_a.delete(); got_b.delete();
    applyStimulus(A2, B2, M);
    wait_done("b2b first done");
    checkOutput("b2b ld_rdy in done cycle", W'(ld_rdy), W'(1));
    applyStimulus(A1, ID, M);
    checkOutput("b2b arr_vld after load", W'(arr_vld), W'(1));
    checkOutput("b2b step0 a", a, 24'h010000);
    checkOutput("b2b step0 b", b, 24'h010000);
    wait_done("b2b second done");
    checkOutput("b2b total beats", W'(got_a.size()), W'(2*NBEATS));
    checkOutput("b2b first a0", (got_a.size() > 0) ? got_a[0] : 'x, 24'h110000);
    checkOutput("b2b second a1", (got_a.size() > NBEATS+1) ? got_a[NBEATS+1] : 'x, 24'h020400);

    @(posedge CLK);
    #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
